i2c_eeprom_slave: RTL and testbench
===================================

# i2c_eeprom_slave

Synthesizable I2C slave model of a 2 Kbyte (24C16-style) serial EEPROM. It sits directly downstream of the EEPROM master controller on the shared SCL/SDA pair and serves as both the bench target and the on-chip emulated EEPROM. It decodes START/STOP, the control byte (device ID, block bits A10..A8, R/W) and the word-address byte. It then performs page writes or sequential/current-address reads on an internal byte array.

## Interface
Parameters:
- `ADDR_W`, 11, byte-address width; array depth is 2^ADDR_W.
- `DEV_ID`, 4'b1010, device-type code expected in control byte bits [7:4].
- `SYNC_STAGES`, 2, synchronizer depth on SCL and SDA inputs (≥2).
- `PAGE_SIZE`, 16, write-page size in bytes (power of two).

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `scl`  in  1  I2C clock from master (asynchronous to `clk`).
- `sda_i`  in  1  resolved SDA line level.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (open drain).
- `busy`  out  1  high from accepted control byte until STOP, NACK or START.
- `mem_we`  out  1  one-cycle strobe when a data byte is committed.
- `mem_addr`  out  ADDR_W  address of committed byte (valid with `mem_we`).
- `mem_wdata`  out  8  committed byte (valid with `mem_we`).

## Operation
- SCL and SDA pass through `SYNC_STAGES` flops. Edges are detected on the synchronized copies.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are recognized in every state.
- Bit timing:
  - Input bits are sampled on SCL rising edges.
  - `sda_oe` changes only on SCL falling edges, except that STOP/START/reset release it immediately.
- FSM states: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: START → CTRL. Everything else is ignored.
- CTRL: shift 8 bits MSB first.
  - If bits [7:4] ≠ DEV_ID: no ACK, return to IDLE.
  - Otherwise latch A10..A8 from bits [3:1] into pointer [10:8] → CTRL_ACK.
- CTRL_ACK: drive ACK for one SCL period.
  - R/W=0 → ADDR.
  - R/W=1 → RDATA, first byte = mem[pointer] (current-address read).
- ADDR: 8 bits load pointer [7:0] → ADDR_ACK (ACK) → WDATA.
- WDATA: after 8th bit:
  - Pulse `mem_we` with `mem_addr`=pointer.
  - Write the array.
  - Increment only the low log2(PAGE_SIZE) pointer bits (page wrap).
  - → WDATA_ACK (ACK) → WDATA.
- RDATA: shift the byte out MSB first → RDATA_ACK (SDA released).
  - Master ACK (SDA low on SCL rise): pointer+1 with full ADDR_W wrap (0x7FF→0x000), next byte → RDATA.
  - Master NACK → IDLE.
- A repeated START in any state → CTRL; the pointer is kept, so a dummy write followed by a read gives a random read.
- A STOP in any state → IDLE. A partially shifted byte is discarded, never written.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, pointer=0, state IDLE. Array contents are not reset.
- Reset mid-transaction: `sda_oe` deasserts in the cycle after `rst` is sampled high.
- Input latency: SYNC_STAGES+1 `clk` cycles from a pin change to internal edge detection.
- SCL high and low phases must each last ≥ SYNC_STAGES+3 `clk` cycles. The bench runs `clk` ≥ 8× SCL rate.
- `sda_oe` updates 1 cycle after a detected SCL fall. SDA setup is therefore met on the next SCL rise.
- `mem_we` asserts 1 cycle after the 8th data-bit SCL rise is detected.
- `busy` rises with the CTRL_ACK entry and falls 1 cycle after STOP, NACK, or a DEV_ID mismatch is detected.

## Configuration
- `EEPROM_SLAVE_WP_EN` defined:
  - Adds input port `wp` (1 bit).
  - While `wp`=1, data bytes are ACKed and the pointer advances, but `mem_we` stays 0 and the array is unchanged.
- Not defined: no `wp` port; writes are always committed.

## Test plan
- Page write: START, 0xA2, 0x34, 0x5A, STOP → three ACKs on `sda_oe`; `mem_we` pulse with `mem_addr`=0x134, `mem_wdata`=0x5A.
- Random read: START, 0xA2, 0x34, repeated START, 0xA3 → slave shifts out 0x5A; master NACK, STOP → `sda_oe`=0, `busy`=0.
- Wrong device: START, 0xB0 → `sda_oe` stays 0 through the 9th clock; following bytes are ignored until the next START.
- Page wrap: write to 0x00E with data 0x11, 0x22, 0x33 → commits at 0x00E, 0x00F, 0x000.
- Sequential read wrap: pointer 0x7FF, read two bytes with master ACK → mem[0x7FF], then mem[0x000].
- Abort handling:
  - STOP after 5 bits of a data byte → no `mem_we`.
  - `rst` asserted while `sda_oe`=1 → `sda_oe`=0 the next cycle, FSM in IDLE.
  - With `EEPROM_SLAVE_WP_EN` and `wp`=1, a page write is ACKed with no `mem_we`.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C slave model of a 2 Kbyte (24C16-style) serial EEPROM.
// Decodes START/STOP, the control byte (device ID, block bits, R/W) and the
// word-address byte, then serves page writes and current/sequential reads
// from an internal byte array.
// Optional feature macro: EEPROM_SLAVE_WP_EN adds a write-protect input `wp`;
// while it is high, data bytes are still ACKed and the pointer still advances,
// but nothing is committed.
// The block bits of the control byte fill pointer[ADDR_W-1:8], so ADDR_W is
// expected to lie in 9..11.
module i2c_eeprom_slave #(
   parameter int         ADDR_W      = 11,
   parameter logic [3:0] DEV_ID      = 4'b1010,
   parameter int         SYNC_STAGES = 2,
   parameter int         PAGE_SIZE   = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef EEPROM_SLAVE_WP_EN
   input  logic              wp,
`endif
   input  logic              scl,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata
);

   localparam int PAGE_BITS = $clog2(PAGE_SIZE);
   localparam int DEPTH     = 1 << ADDR_W;
   localparam logic [PAGE_BITS-1:0] PAGE_ONE = {{(PAGE_BITS-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]    ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE,
      S_CTRL,
      S_CTRL_ACK,
      S_ADDR,
      S_ADDR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK
   } state_t;

   // Synchronizers and previous-value registers for edge detection
   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   // FSM and datapath state
   state_t            state_q;
   logic [2:0]        bit_cnt_q;
   logic [6:0]        shift_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              rw_q;
   logic              ack_phase_q;  // slave ACK: 0 = not yet driving, 1 = driving
   logic              acked_q;      // read: master ACK seen, load next byte on fall
   logic              sda_oe_q;
   logic              busy_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;

   logic [7:0] mem_q [0:DEPTH-1];

   logic       scl_s;
   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       last_bit;
   logic [7:0] byte_in;
   logic [7:0] rd_byte;
   logic       wr_block;
   logic       commit_en;

`ifdef EEPROM_SLAVE_WP_EN
   assign wr_block = wp;
`else
   assign wr_block = 1'b0;
`endif

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   // START/STOP need SCL high on both samples so an SDA change that lands
   // together with an SCL edge is never mistaken for a bus condition.
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign last_bit  = (bit_cnt_q == 3'd7);
   assign byte_in   = {shift_q, sda_s};
   assign rd_byte   = mem_q[ptr_q];
   assign commit_en = ~rst & (state_q == S_WDATA) & scl_rise & last_bit & ~wr_block;

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Bring SCL/SDA into the clk domain; idle bus level is high
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   // Byte array write port; contents survive reset
   always_ff @(posedge clk) begin
      if (commit_en) begin
         mem_q[ptr_q] <= byte_in;
      end
   end

   // Protocol FSM: bits sampled on SCL rise, sda_oe moved only on SCL fall
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 7'd0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         ack_phase_q <= 1'b0;
         acked_q     <= 1'b0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
      end else begin
         mem_we_q <= 1'b0;
         if (start_det) begin
            // Repeated START keeps the pointer so dummy-write + read works
            state_q     <= S_CTRL;
            bit_cnt_q   <= 3'd0;
            ack_phase_q <= 1'b0;
            acked_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
         end else if (stop_det) begin
            // Any partially shifted byte is simply dropped
            state_q     <= S_IDLE;
            ack_phase_q <= 1'b0;
            acked_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
               end

               S_CTRL: begin
                  if (scl_rise) begin
                     shift_q   <= byte_in[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) begin
                        if (byte_in[7:4] != DEV_ID) begin
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                        end else begin
                           ptr_q[ADDR_W-1:8] <= byte_in[ADDR_W-8:1];
                           rw_q              <= byte_in[0];
                           busy_q            <= 1'b1;
                           ack_phase_q       <= 1'b0;
                           state_q           <= S_CTRL_ACK;
                        end
                     end
                  end
               end

               S_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= byte_in[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) begin
                        ptr_q[7:0]  <= byte_in;
                        ack_phase_q <= 1'b0;
                        state_q     <= S_ADDR_ACK;
                     end
                  end
               end

               S_WDATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_in[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) begin
                        if (!wr_block) begin
                           mem_we_q    <= 1'b1;
                           mem_addr_q  <= ptr_q;
                           mem_wdata_q <= byte_in;
                        end
                        // Page wrap: only the in-page bits advance
                        ptr_q[PAGE_BITS-1:0] <= ptr_q[PAGE_BITS-1:0] + PAGE_ONE;
                        ack_phase_q          <= 1'b0;
                        state_q              <= S_WDATA_ACK;
                     end
                  end
               end

               S_CTRL_ACK, S_ADDR_ACK, S_WDATA_ACK: begin
                  // First fall starts the ACK, second fall (after the 9th rise) ends it
                  if (scl_fall) begin
                     if (!ack_phase_q) begin
                        sda_oe_q    <= 1'b1;
                        ack_phase_q <= 1'b1;
                     end else begin
                        ack_phase_q <= 1'b0;
                        bit_cnt_q   <= 3'd0;
                        if ((state_q == S_CTRL_ACK) && rw_q) begin
                           shift_q  <= rd_byte[6:0];
                           sda_oe_q <= ~rd_byte[7];
                           state_q  <= S_RDATA;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= (state_q == S_CTRL_ACK) ? S_ADDR : S_WDATA;
                        end
                     end
                  end
               end

               S_RDATA: begin
                  if (scl_fall) begin
                     sda_oe_q <= ~shift_q[6];
                     shift_q  <= {shift_q[5:0], 1'b0};
                  end
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) begin
                        acked_q <= 1'b0;
                        state_q <= S_RDATA_ACK;
                     end
                  end
               end

               S_RDATA_ACK: begin
                  if (scl_fall) begin
                     if (acked_q) begin
                        acked_q   <= 1'b0;
                        bit_cnt_q <= 3'd0;
                        shift_q   <= rd_byte[6:0];
                        sda_oe_q  <= ~rd_byte[7];
                        state_q   <= S_RDATA;
                     end else begin
                        sda_oe_q <= 1'b0;
                     end
                  end
                  if (scl_rise) begin
                     if (!sda_s) begin
                        ptr_q   <= ptr_q + ADDR_ONE;
                        acked_q <= 1'b1;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end

               default: begin
                  state_q  <= S_IDLE;
                  sda_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bit-banged I2C master driving i2c_eeprom_slave, with a
// commit scoreboard (exp_q), a read-data queue (rd_exp_q) and a byte-array model.
module tb_i2c_eeprom_slave;

   localparam int HALF = 8;   // clk cycles per SCL half period

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        master_sda;   // 1 = master releases SDA
   logic        sda_line;
   logic        sda_oe;
   logic        busy;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata;
`ifdef EEPROM_SLAVE_WP_EN
   logic        wp;
`endif

   int checks   = 0;
   int failures = 0;
   int we_count = 0;

   logic [18:0] exp_q[$];
   logic [7:0]  rd_exp_q[$];
   logic [7:0]  model_mem [0:2047];
   logic [7:0]  wbuf [0:3];
   logic [7:0]  rbuf [0:3];
   logic [18:0] mon_exp;

   assign sda_line = master_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_eeprom_slave dut (
      .clk       (clk),
      .rst       (rst),
`ifdef EEPROM_SLAVE_WP_EN
      .wp        (wp),
`endif
      .scl       (scl),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

   // Commit monitor: every mem_we pulse is checked against the expected queue
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_count++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL mem_we_unexpected addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== mon_exp)
               begin
                  failures++;
                  $display("FAIL mem_commit got addr=%h data=%h exp addr=%h data=%h",
                           mem_addr, mem_wdata, mon_exp[18:8], mon_exp[7:0]);
               end
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period starting from SCL low; samples line/oe mid-high
   task automatic clock_bit(input logic b, output logic line, output logic oe);
      wait_clks(2);
      master_sda = b;
      wait_clks(HALF - 2);
      scl = 1'b1;
      wait_clks(HALF / 2);
      line = sda_line;
      oe   = sda_oe;
      wait_clks(HALF / 2);
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         wait_clks(2);
         master_sda = 1'b1;
         wait_clks(HALF - 2);
         scl = 1'b1;
         wait_clks(HALF);
      end
      master_sda = 1'b0;
      wait_clks(HALF);
      scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clks(2);
      master_sda = 1'b0;
      wait_clks(HALF - 2);
      scl = 1'b1;
      wait_clks(HALF);
      master_sda = 1'b1;
      wait_clks(HALF);
   endtask

   // Eight data bits then the ACK clock; ack = slave pulled SDA in the 9th high
   task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe_bits);
      logic l, o;
      oe_bits = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(b[i], l, o);
         if (o) oe_bits = 1'b1;
      end
      clock_bit(1'b1, l, o);
      ack = o & ~l;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic l, o;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, l, o);
         b[i] = l;
      end
      clock_bit(~mack, l, o);
   endtask

   task automatic page_write(input logic [10:0] addr, input int n,
                             output int acks, output int oe_bad);
      logic a, o;
      acks = 0;
      oe_bad = 0;
      i2c_start();
      write_byte({4'hA, addr[10:8], 1'b0}, a, o);
      if (a) acks++;
      if (o) oe_bad++;
      write_byte(addr[7:0], a, o);
      if (a) acks++;
      if (o) oe_bad++;
      for (int k = 0; k < n; k++) begin
         write_byte(wbuf[k], a, o);
         if (a) acks++;
         if (o) oe_bad++;
      end
      i2c_stop();
   endtask

   // Dummy write of the address, repeated START, then n bytes (last one NACKed)
   task automatic rand_read(input logic [10:0] addr, input int n, output int acks);
      logic a, o;
      logic [7:0] b;
      acks = 0;
      i2c_start();
      write_byte({4'hA, addr[10:8], 1'b0}, a, o);
      if (a) acks++;
      write_byte(addr[7:0], a, o);
      if (a) acks++;
      i2c_start();
      write_byte({4'hA, addr[10:8], 1'b1}, a, o);
      if (a) acks++;
      for (int k = 0; k < n; k++) begin
         read_byte(k != n - 1, b);
         rbuf[k] = b;
      end
      i2c_stop();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      scl = 1'b1;
      master_sda = 1'b1;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 11'h000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
   endtask

   task automatic test_page_write();
      logic a, o;
      int base;
      base = we_count;
      exp_q.push_back({11'h134, 8'h5A});
      model_mem[11'h134] = 8'h5A;
      i2c_start();
      write_byte(8'hA2, a, o);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL pw_ctrl_ack got=%b exp=1", a); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL pw_ctrl_bits_oe got=%b exp=0", o); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pw_busy_high got=%b exp=1", busy); end
      write_byte(8'h34, a, o);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL pw_addr_ack got=%b exp=1", a); end
      write_byte(8'h5A, a, o);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL pw_data_ack got=%b exp=1", a); end
      i2c_stop();
      wait_clks(2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pw_busy_low got=%b exp=0", busy); end
      checks++; if (we_count - base != 1) begin failures++; $display("FAIL pw_we_count got=%0d exp=1", we_count - base); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pw_exp_left got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_random_read();
      int acks;
      logic [7:0] e;
      rd_exp_q.push_back(model_mem[11'h134]);
      rand_read(11'h134, 1, acks);
      checks++; if (acks != 3) begin failures++; $display("FAIL rr_acks got=%0d exp=3", acks); end
      e = rd_exp_q.pop_front();
      checks++; if (rbuf[0] !== e) begin failures++; $display("FAIL rr_data got=%h exp=%h", rbuf[0], e); end
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rr_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_busy got=%b exp=0", busy); end
   endtask

   task automatic test_wrong_device();
      logic a, o;
      int base;
      base = we_count;
      i2c_start();
      write_byte(8'hB0, a, o);
      checks++; if (a !== 1'b0) begin failures++; $display("FAIL wd_ctrl_ack got=%b exp=0", a); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL wd_bits_oe got=%b exp=0", o); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%b exp=0", busy); end
      write_byte(8'h34, a, o);
      checks++; if (a !== 1'b0) begin failures++; $display("FAIL wd_follow_ack got=%b exp=0", a); end
      write_byte(8'h5A, a, o);
      checks++; if (a !== 1'b0) begin failures++; $display("FAIL wd_follow2_ack got=%b exp=0", a); end
      i2c_stop();
      wait_clks(2);
      checks++; if (we_count != base) begin failures++; $display("FAIL wd_no_commit got=%0d exp=%0d", we_count, base); end
   endtask

   task automatic test_page_wrap();
      int acks, oe_bad;
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      exp_q.push_back({11'h00E, 8'h11});
      exp_q.push_back({11'h00F, 8'h22});
      exp_q.push_back({11'h000, 8'h33});
      model_mem[11'h00E] = 8'h11;
      model_mem[11'h00F] = 8'h22;
      model_mem[11'h000] = 8'h33;
      page_write(11'h00E, 3, acks, oe_bad);
      wait_clks(2);
      checks++; if (acks != 5) begin failures++; $display("FAIL wrap_acks got=%0d exp=5", acks); end
      checks++; if (oe_bad != 0) begin failures++; $display("FAIL wrap_bits_oe got=%0d exp=0", oe_bad); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_exp_left got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_seq_read_wrap();
      int acks, oe_bad;
      logic [7:0] e;
      wbuf[0] = 8'hC7;
      exp_q.push_back({11'h7FF, 8'hC7});
      model_mem[11'h7FF] = 8'hC7;
      page_write(11'h7FF, 1, acks, oe_bad);
      checks++; if (acks != 3) begin failures++; $display("FAIL srw_write_acks got=%0d exp=3", acks); end
      rd_exp_q.push_back(model_mem[11'h7FF]);
      rd_exp_q.push_back(model_mem[11'h000]);
      rand_read(11'h7FF, 2, acks);
      checks++; if (acks != 3) begin failures++; $display("FAIL srw_read_acks got=%0d exp=3", acks); end
      for (int k = 0; k < 2; k++) begin
         e = rd_exp_q.pop_front();
         checks++;
         if (rbuf[k] !== e) begin failures++; $display("FAIL srw_data%0d got=%h exp=%h", k, rbuf[k], e); end
      end
   endtask

   task automatic test_abort_stop();
      logic a, o, l;
      int base;
      base = we_count;
      i2c_start();
      write_byte(8'hA0, a, o);
      write_byte(8'h40, a, o);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL abort_addr_ack got=%b exp=1", a); end
      for (int i = 7; i >= 3; i--) clock_bit(i[0], l, o);
      i2c_stop();
      wait_clks(4);
      checks++; if (we_count != base) begin failures++; $display("FAIL abort_no_commit got=%0d exp=%0d", we_count, base); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic a, o, l;
      logic [7:0] c;
      c = 8'hA0;
      i2c_start();
      for (int i = 7; i >= 0; i--) clock_bit(c[i], l, o);
      wait_clks(2);
      master_sda = 1'b1;
      wait_clks(HALF / 2);
      checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rm_ack_driven got=%b exp=1", sda_oe); end
      rst = 1'b1;
      wait_clks(1);
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rm_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      rst = 1'b0;
      wait_clks(2);
      scl = 1'b1;
      wait_clks(HALF);
      scl = 1'b0;
      // No START since reset, so the slave must stay silent
      write_byte(8'hA0, a, o);
      checks++; if (a !== 1'b0 || o !== 1'b0) begin failures++; $display("FAIL rm_idle_ack got=%b/%b exp=0/0", a, o); end
      i2c_stop();
   endtask

   task automatic test_back_to_back();
      int acks, oe_bad, blk, pg, off;
      logic [10:0] addr;
      logic [7:0] e;
      for (int it = 0; it < 2; it++) begin
         blk = $urandom_range(0, 7);
         pg  = $urandom_range(0, 15);
         off = $urandom_range(0, 12);
         addr = {blk[2:0], pg[3:0], off[3:0]};
         for (int k = 0; k < 4; k++) begin
            wbuf[k] = 8'($urandom_range(0, 255));
            exp_q.push_back({addr + 11'(k), wbuf[k]});
            model_mem[addr + 11'(k)] = wbuf[k];
         end
         page_write(addr, 4, acks, oe_bad);
         wait_clks(2);
         checks++; if (acks != 6) begin failures++; $display("FAIL b2b_write_acks got=%0d exp=6", acks); end
         checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_exp_left got=%0d exp=0", exp_q.size()); end
         for (int k = 0; k < 4; k++) rd_exp_q.push_back(model_mem[addr + 11'(k)]);
         rand_read(addr, 4, acks);
         checks++; if (acks != 3) begin failures++; $display("FAIL b2b_read_acks got=%0d exp=3", acks); end
         for (int k = 0; k < 4; k++) begin
            e = rd_exp_q.pop_front();
            checks++;
            if (rbuf[k] !== e) begin failures++; $display("FAIL b2b_data addr=%h got=%h exp=%h", addr + 11'(k), rbuf[k], e); end
         end
      end
   endtask

`ifdef EEPROM_SLAVE_WP_EN
   task automatic test_write_protect();
      int acks, oe_bad, base;
      logic [7:0] e;
      base = we_count;
      wp = 1'b1;
      wbuf[0] = 8'h66;
      page_write(11'h134, 1, acks, oe_bad);
      wait_clks(2);
      wp = 1'b0;
      checks++; if (acks != 3) begin failures++; $display("FAIL wp_acks got=%0d exp=3", acks); end
      checks++; if (we_count != base) begin failures++; $display("FAIL wp_no_commit got=%0d exp=%0d", we_count, base); end
      rd_exp_q.push_back(model_mem[11'h134]);
      rand_read(11'h134, 1, acks);
      e = rd_exp_q.pop_front();
      checks++; if (rbuf[0] !== e) begin failures++; $display("FAIL wp_array_kept got=%h exp=%h", rbuf[0], e); end
   endtask
`endif

   initial begin
`ifdef EEPROM_SLAVE_WP_EN
      wp = 1'b0;
`endif
      test_reset();
      test_page_write();
      test_random_read();
      test_wrong_device();
      test_page_wrap();
      test_seq_read_wrap();
      test_abort_stop();
      test_reset_mid();
      test_back_to_back();
`ifdef EEPROM_SLAVE_WP_EN
      test_write_protect();
`endif
      wait_clks(4);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL final_exp_left got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
